// File: rtl/bf16_fpu_pkg.sv
// Shared types and constants for the bfloat16 FPU issuer.
package bf16_fpu_pkg;

  localparam int unsigned CMD_DATA_W = 16;
  localparam int unsigned CMD_OP_W   = 4;

  localparam logic [CMD_OP_W-1:0]   OP_ADD    = 4'b0001;
  localparam logic [CMD_OP_W-1:0]   OP_SUB    = 4'b0010;
  localparam logic [CMD_OP_W-1:0]   OP_MUL    = 4'b0100;
  localparam logic [CMD_OP_W-1:0]   OP_DIV    = 4'b1000;
  localparam logic [CMD_DATA_W-1:0] BF16_QNAN = 16'h7FC0;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  typedef struct packed {
    logic [CMD_OP_W-1:0]   op;
    logic [CMD_DATA_W-1:0] a;
    logic [CMD_DATA_W-1:0] b;
  } fpu_cmd_t;

  localparam int unsigned CMD_W = $bits(fpu_cmd_t);

  // True when exactly one opcode bit is set.
  function automatic logic op_is_onehot(input logic [CMD_OP_W-1:0] op);
    return (op != '0) && ((op & (op - CMD_OP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/bf16_cmd_fifo.sv
// Synchronous command FIFO; occupancy counter distinguishes full from empty.
module bf16_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_eff_c;
  logic             pop_eff_c;

  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign push_eff_c = push_i & ~full_o;
  assign pop_eff_c  = pop_i & ~empty_o;
  assign data_o     = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_eff_c) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = PTR_W'(wr_ptr_q + PTR_W'(1));
    end
    if (pop_eff_c) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
    end
    case ({push_eff_c, pop_eff_c})
      2'b10:   cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      2'b01:   cnt_d = CNT_W'(cnt_q - CNT_W'(1));
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bf16_fpu_issuer.sv
// Buffers bf16 FPU commands, issues one per cycle to a combinational fpu and
// returns registered results in order. Optional issue counter: FPU_ISSUER_STATS_EN.
module bf16_fpu_issuer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned OP_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [OP_W-1:0]   cmd_op_i,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_ovf_o,
  output logic              err_op_o,
  output logic [15:0]       issued_cnt_o,
  output logic [OP_W-1:0]   fpu_op_o,
  output logic [DATA_W-1:0] fpu_in1_o,
  output logic [DATA_W-1:0] fpu_in2_o,
  input  logic [DATA_W-1:0] fpu_out_i,
  input  logic              fpu_ovf_i
);

  import bf16_fpu_pkg::*;

  fpu_cmd_t          push_cmd;
  fpu_cmd_t          head_cmd;
  logic [CMD_W-1:0]  fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_c;
  logic              issue_c;
  logic              head_legal_c;

  res_state_e        state_q, state_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_ovf_q, res_ovf_d;
  logic              err_op_q, err_op_d;

  // Pack the incoming command.
  always_comb begin
    push_cmd.op = CMD_OP_W'(cmd_op_i);
    push_cmd.a  = CMD_DATA_W'(cmd_a_i);
    push_cmd.b  = CMD_DATA_W'(cmd_b_i);
  end

  assign cmd_ready_o  = ~fifo_full;
  assign push_c       = cmd_valid_i & ~fifo_full;
  assign head_cmd     = fpu_cmd_t'(fifo_rd_data);
  assign head_legal_c = op_is_onehot(head_cmd.op);
  assign issue_c      = ~fifo_empty & ((state_q == RES_EMPTY) | res_ready_i);

  bf16_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (issue_c),
    .data_i  (push_cmd),
    .data_o  (fifo_rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Drive the fpu from the FIFO head; illegal opcodes are never presented.
  always_comb begin
    fpu_op_o  = '0;
    fpu_in1_o = '0;
    fpu_in2_o = '0;
    if (!fifo_empty) begin
      if (head_legal_c) begin
        fpu_op_o = OP_W'(head_cmd.op);
      end
      fpu_in1_o = DATA_W'(head_cmd.a);
      fpu_in2_o = DATA_W'(head_cmd.b);
    end
  end

  // Result FSM next state, result capture and sticky opcode error.
  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    err_op_d   = err_op_q;
    if (issue_c) begin
      state_d = RES_FULL;
      if (head_legal_c) begin
        res_data_d = fpu_out_i;
        res_ovf_d  = fpu_ovf_i;
      end else begin
        res_data_d = DATA_W'(BF16_QNAN);
        res_ovf_d  = 1'b0;
        err_op_d   = 1'b1;
      end
    end else if ((state_q == RES_FULL) && res_ready_i) begin
      state_d = RES_EMPTY;
    end
  end

  // Result FSM state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RES_EMPTY;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      err_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      err_op_q   <= err_op_d;
    end
  end

  assign res_valid_o = (state_q == RES_FULL);
  assign res_data_o  = res_data_q;
  assign res_ovf_o   = res_ovf_q;
  assign err_op_o    = err_op_q;

`ifdef FPU_ISSUER_STATS_EN
  logic [15:0] issued_cnt_q, issued_cnt_d;

  // Count every issue, legal or not; wraps naturally.
  always_comb begin
    issued_cnt_d = issued_cnt_q;
    if (issue_c) begin
      issued_cnt_d = 16'(issued_cnt_q + 16'd1);
    end
  end

  // Issue counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt_q <= '0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign issued_cnt_o = issued_cnt_q;
`else
  assign issued_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bf16_fpu_issuer.sv
// Self-checking bench for bf16_fpu_issuer with a stand-in fpu and an in-order scoreboard.
module tb_bf16_fpu_issuer;
  import bf16_fpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [3:0]  cmd_op_i;
  logic [15:0] cmd_a_i;
  logic [15:0] cmd_b_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_data_o;
  logic        res_ovf_o;
  logic        err_op_o;
  logic [15:0] issued_cnt_o;
  logic [3:0]  fpu_op_o;
  logic [15:0] fpu_in1_o;
  logic [15:0] fpu_in2_o;
  logic [15:0] fpu_out_i;
  logic        fpu_ovf_i;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  fpu_cmd_t exp_q[$];

  bf16_fpu_issuer #(.FIFO_DEPTH(DEPTH), .DATA_W(16), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_ovf_o(res_ovf_o),
    .err_op_o(err_op_o), .issued_cnt_o(issued_cnt_o),
    .fpu_op_o(fpu_op_o), .fpu_in1_o(fpu_in1_o), .fpu_in2_o(fpu_in2_o),
    .fpu_out_i(fpu_out_i), .fpu_ovf_i(fpu_ovf_i)
  );

  always #5 clk = ~clk;

  // Stand-in fpu: exact bf16 answers for the named cases, a scrambler otherwise.
  function automatic logic [16:0] fpu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == OP_ADD && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
    if (op == OP_ADD && a == 16'h3F80 && b == 16'h3F80) return {1'b0, 16'h4000};
    if (op == OP_MUL && a == 16'h4000 && b == 16'h4040) return {1'b0, 16'h40C0};
    if (op == OP_SUB && a == 16'h4040 && b == 16'h3F80) return {1'b0, 16'h4000};
    if (op == OP_MUL && a == 16'h7F7F && b == 16'h4000) return {1'b1, 16'h7F80};
    return {(op == OP_MUL) && a[14] && b[14], 16'((a ^ {b[7:0], b[15:8]}) + 16'(op) * 16'h1357)};
  endfunction

  always_comb {fpu_ovf_i, fpu_out_i} = fpu_model(fpu_op_o, fpu_in1_o, fpu_in2_o);

  // Expected {ovf, data} for a command as seen by the host.
  function automatic logic [16:0] expect_res(input fpu_cmd_t c);
    if ($countones(c.op) == 1) return fpu_model(c.op, c.a, c.b);
    return {1'b0, 16'h7FC0};
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef FPU_ISSUER_STATS_EN
    return 16'(n_acc);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_a_i     = a;
    cmd_b_i     = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid_i = 1'b0; res_ready_i = 1'b0;
    cmd_op_i = '0; cmd_a_i = '0; cmd_b_i = '0;
    tick(); tick();
    rst = 1'b0;
    n_acc = 0; exp_q.delete();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", res_valid_o); end
    checks++; if (res_data_o !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", res_data_o); end
    checks++; if (res_ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", res_ovf_o); end
    checks++; if (err_op_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_op_o); end
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", cmd_ready_o); end
    checks++; if (issued_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0000", issued_cnt_o); end
  endtask

  task automatic test_single_add();
    res_ready_i = 1'b1;
    drive_cmd(OP_ADD, 16'h3F80, 16'h4000);
    tick(); n_acc++;
    cmd_valid_i = 1'b0;
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL add_no_bypass got %0b want 0", res_valid_o); end
    checks++; if (fpu_op_o !== OP_ADD || fpu_in1_o !== 16'h3F80 || fpu_in2_o !== 16'h4000) begin
      errors++; $display("FAIL add_fpu_drive got %b/%h/%h want 0001/3f80/4000", fpu_op_o, fpu_in1_o, fpu_in2_o); end
    tick();
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 16'h4040 || res_ovf_o !== 1'b0) begin
      errors++; $display("FAIL add_result got v%0b %h o%0b want v1 4040 o0", res_valid_o, res_data_o, res_ovf_o); end
    checks++; if (fpu_op_o !== 4'h0 || fpu_in1_o !== 16'h0) begin
      errors++; $display("FAIL add_fpu_idle got %b/%h want 0000/0000", fpu_op_o, fpu_in1_o); end
    tick();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL add_consumed got %0b want 0", res_valid_o); end
  endtask

  task automatic test_streaming();
    res_ready_i = 1'b1;
    drive_cmd(OP_MUL, 16'h4000, 16'h4040);
    tick(); n_acc++;
    drive_cmd(OP_SUB, 16'h4040, 16'h3F80);
    tick(); n_acc++;
    cmd_valid_i = 1'b0;
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 16'h40C0) begin
      errors++; $display("FAIL stream_first got v%0b %h want v1 40c0", res_valid_o, res_data_o); end
    tick();
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 16'h4000) begin
      errors++; $display("FAIL stream_second got v%0b %h want v1 4000", res_valid_o, res_data_o); end
    tick();
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL stream_end got %0b want 0", res_valid_o); end
  endtask

  task automatic test_overflow();
    logic [16:0] e;
    res_ready_i = 1'b1;
    e = fpu_model(OP_MUL, 16'h7F7F, 16'h4000);
    drive_cmd(OP_MUL, 16'h7F7F, 16'h4000);
    tick(); n_acc++;
    cmd_valid_i = 1'b0;
    tick();
    checks++; if (res_valid_o !== 1'b1 || res_ovf_o !== 1'b1 || res_data_o !== e[15:0]) begin
      errors++; $display("FAIL ovf_result got v%0b %h o%0b want v1 %h o1", res_valid_o, res_data_o, res_ovf_o, e[15:0]); end
    tick();
    checks++; if (issued_cnt_o !== exp_cnt()) begin errors++; $display("FAIL ovf_cnt got %h want %h", issued_cnt_o, exp_cnt()); end
  endtask

  task automatic test_backpressure();
    fpu_cmd_t c;
    logic [16:0] e;
    int acc = 0;
    res_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c.op = OP_ADD << $urandom_range(0, 3);
      c.a = 16'($urandom); c.b = 16'($urandom);
      drive_cmd(c.op, c.a, c.b);
      if (cmd_ready_o) begin acc++; n_acc++; exp_q.push_back(c); end
      tick();
    end
    cmd_valid_i = 1'b0;
    checks++; if (acc != 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", acc); end
    checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %0b want 0", cmd_ready_o); end
    e = expect_res(exp_q[0]);
    for (int i = 0; i < 3; i++) begin
      checks++; if (res_valid_o !== 1'b1 || res_data_o !== e[15:0] || res_ovf_o !== e[16]) begin
        errors++; $display("FAIL bp_hold got v%0b %h o%0b want v1 %h o%0b", res_valid_o, res_data_o, res_ovf_o, e[15:0], e[16]); end
      tick();
    end
    res_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = (exp_q.size() > 0) ? expect_res(exp_q.pop_front()) : 17'h0;
      checks++; if (res_valid_o !== 1'b1 || res_data_o !== e[15:0] || res_ovf_o !== e[16]) begin
        errors++; $display("FAIL bp_drain%0d got v%0b %h o%0b want v1 %h o%0b", i, res_valid_o, res_data_o, res_ovf_o, e[15:0], e[16]); end
      tick();
    end
    checks++; if (res_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_idle got v%0b r%0b want v0 r1", res_valid_o, cmd_ready_o); end
    checks++; if (issued_cnt_o !== exp_cnt()) begin errors++; $display("FAIL bp_cnt got %h want %h", issued_cnt_o, exp_cnt()); end
  endtask

  task automatic test_illegal();
    res_ready_i = 1'b1;
    drive_cmd(4'b0011, 16'h1234, 16'h5678);
    tick(); n_acc++;
    cmd_valid_i = 1'b0;
    checks++; if (fpu_op_o !== 4'b0000 || fpu_in1_o !== 16'h1234) begin
      errors++; $display("FAIL ill_fpu_op got %b/%h want 0000/1234", fpu_op_o, fpu_in1_o); end
    tick();
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 16'h7FC0 || res_ovf_o !== 1'b0) begin
      errors++; $display("FAIL ill_result got v%0b %h o%0b want v1 7fc0 o0", res_valid_o, res_data_o, res_ovf_o); end
    checks++; if (err_op_o !== 1'b1) begin errors++; $display("FAIL ill_err got %0b want 1", err_op_o); end
    drive_cmd(OP_ADD, 16'h3F80, 16'h4000);
    tick(); n_acc++;
    cmd_valid_i = 1'b0;
    tick();
    checks++; if (res_data_o !== 16'h4040 || err_op_o !== 1'b1) begin
      errors++; $display("FAIL ill_sticky got %h e%0b want 4040 e1", res_data_o, err_op_o); end
    tick();
  endtask

  task automatic test_random();
    fpu_cmd_t c;
    logic [16:0] e;
    logic exp_rdy;
    int budget;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 7) == 0) begin
        do c.op = 4'($urandom); while ($countones(c.op) == 1);
      end else begin
        c.op = OP_ADD << $urandom_range(0, 3);
      end
      c.a = 16'($urandom); c.b = 16'($urandom);
      drive_cmd(c.op, c.a, c.b);
      cmd_valid_i = ($urandom_range(0, 99) < 60);
      res_ready_i = ($urandom_range(0, 99) < 50);
      #1;
      exp_rdy = (exp_q.size() - int'(res_valid_o)) < DEPTH;
      checks++; if (cmd_ready_o !== exp_rdy) begin
        errors++; $display("FAIL rand_ready cyc%0d got %0b want %0b", cyc, cmd_ready_o, exp_rdy); end
      if (res_valid_o && res_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc%0d got %h want no result", cyc, res_data_o);
        end else begin
          e = expect_res(exp_q.pop_front());
          if (res_data_o !== e[15:0] || res_ovf_o !== e[16]) begin
            errors++; $display("FAIL rand_data cyc%0d got %h o%0b want %h o%0b", cyc, res_data_o, res_ovf_o, e[15:0], e[16]); end
        end
      end
      if (cmd_valid_i && cmd_ready_o) begin exp_q.push_back(c); n_acc++; end
      tick();
    end
    cmd_valid_i = 1'b0; res_ready_i = 1'b1;
    budget = 50;
    while (exp_q.size() > 0 && budget > 0) begin
      if (res_valid_o) begin
        e = expect_res(exp_q.pop_front());
        checks++; if (res_data_o !== e[15:0] || res_ovf_o !== e[16]) begin
          errors++; $display("FAIL rand_drain got %h o%0b want %h o%0b", res_data_o, res_ovf_o, e[15:0], e[16]); end
      end
      tick();
      budget--;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_timeout got %0d left want 0", exp_q.size()); end
    checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL rand_idle got %0b want 0", res_valid_o); end
    checks++; if (issued_cnt_o !== exp_cnt()) begin errors++; $display("FAIL rand_cnt got %h want %h", issued_cnt_o, exp_cnt()); end
  endtask

  task automatic test_reset_mid();
    res_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(OP_SUB, 16'($urandom), 16'($urandom));
      tick();
    end
    cmd_valid_i = 1'b0;
    checks++; if (res_valid_o !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %0b want 1", res_valid_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_acc = 0; exp_q.delete();
    checks++; if (res_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || err_op_o !== 1'b0 || res_data_o !== 16'h0) begin
      errors++; $display("FAIL rm_state got v%0b r%0b e%0b %h want v0 r1 e0 0000", res_valid_o, cmd_ready_o, err_op_o, res_data_o); end
    checks++; if (issued_cnt_o !== 16'h0) begin errors++; $display("FAIL rm_cnt got %h want 0000", issued_cnt_o); end
    res_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL rm_stale%0d got %0b want 0", i, res_valid_o); end
    end
    drive_cmd(OP_ADD, 16'h3F80, 16'h3F80);
    tick(); n_acc++;
    cmd_valid_i = 1'b0;
    tick();
    checks++; if (res_valid_o !== 1'b1 || res_data_o !== 16'h4000) begin
      errors++; $display("FAIL rm_after got v%0b %h want v1 4000", res_valid_o, res_data_o); end
    tick();
    checks++; if (issued_cnt_o !== exp_cnt()) begin errors++; $display("FAIL rm_after_cnt got %h want %h", issued_cnt_o, exp_cnt()); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_streaming();
    test_overflow();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
